gbx_arbiter2: RTL and testbench
===============================

// Module: gbx_arbiter2
//
// PURPOSE
// - Two-master to one-slave arbiter for the GBX request/response bus (e.g. fetch port m0 and data port m1
//   sharing one GBXSRAM or other GBX slave).
// - Round-robin grant on the request channel, zero-cycle combinational pass-through.
// - In-order response routing, using a tag FIFO of granted read requests.
// - Single-beat transactions only (len=0, dlast=1). Len and dlast are forwarded unchanged.
//
// PARAMETERS
// - OUTSTANDING  4  Depth of the read-tag FIFO. Power of two, >= 2. Maximum reads in flight.
//
// PORTS
// - clk                                   in   1             Clock.
// - reset                                 in   1             Synchronous, active-high reset.
// - mN_greqvalid (N=0,1)                  in   1             Master N request valid.
// - mN_greqwrite                          in   1             Master N request is a write.
// - mN_greqaddr/len/id/size               in   32/4/16/2     Master N request fields.
// - mN_greqdvalid/data/dlast/user         in   1/32/1/16     Master N write data and user fields.
// - mN_greqready                          out  1             Request accepted from master N.
// - mN_grspvalid                          out  1             Response valid to master N.
// - mN_grspdata/werr/rerr/id/last/user    out  32/1/1/16/1/16  Response fields (slave fields broadcast).
// - mN_grspready                          in   1             Master N response ready.
// - s_greq* (same set as mN_greq*)        out  as above      Request fields to the slave.
// - s_greqready                           in   1             Slave request ready.
// - s_grsp* (valid/data/werr/rerr/id/last/user)  in  as above  Response from the slave.
// - s_grspready                           out  1             Response ready to the slave.
// - err_orphan                            out  1             Sticky: slave response seen with tag FIFO empty.
//
// BEHAVIOUR
// - Reset values:
//   - rr_ptr=0 (master 0 preferred); lock=0; tag FIFO empty; err_orphan=0.
//   - All mN_greqready, mN_grspvalid and s_greqvalid are 0 while the inputs are idle.
// - Grant selection (combinational):
//   - If lock=1, grant = lock_idx.
//   - Otherwise, if only one master is valid, grant it.
//   - If both are valid, grant rr_ptr.
//   - If neither is valid, no grant: s_greqvalid=0.
// - Request path:
//   - s_greq* = granted master's fields.
//   - s_greqvalid = granted valid AND !full.
//   - mG_greqready = s_greqready AND !full. The non-granted master's ready is 0.
// - Lock:
//   - Set when s_greqvalid=1 AND s_greqready=0; lock_idx = grant.
//   - Cleared on acceptance (s_greqvalid AND s_greqready).
//   - Guarantees a stable grant while a request is stalled; no master switch mid-request.
// - Acceptance:
//   - rr_ptr <= ~grant.
//   - If the accepted request is a read (greqwrite=0), push grant index into the tag FIFO.
//   - Writes push nothing; the slave returns no write response.
// - Full:
//   - full = (count == OUTSTANDING).
//   - All requests, reads and writes, are stalled while full.
//   - A pop in the same cycle does NOT unblock: full is evaluated from the registered count.
// - Response path (combinational):
//   - head = FIFO head index.
//   - m[head]_grspvalid = s_grspvalid AND !empty. The other master's grspvalid = 0.
//   - s_grspready = m[head]_grspready when !empty.
//   - Pop when s_grspvalid AND s_grspready AND s_grsplast.
// - Orphan response:
//   - Condition: s_grspvalid with FIFO empty.
//   - s_grspready=1 (drain), no master sees valid, err_orphan <= 1 (sticky until reset).
// - Simultaneous push and pop: count unchanged, pointers both advance. Legal when not full.
// - Count and pointers:
//   - count is log2(OUTSTANDING)+1 bits.
//   - Read/write pointers are log2(OUTSTANDING) bits and wrap modulo OUTSTANDING.
// - Latency:
//   - Request: 0 cycles added.
//   - Response: 0 cycles added.
//   - Arbitration fairness: a waiting master is granted within 1 acceptance of the other master.
// - Reset mid-operation:
//   - FIFO, lock and rr_ptr are cleared immediately.
//   - Slave responses arriving after reset are treated as orphans.
//
// TESTING
// - Both masters assert reads continuously, s_greqready=1:
//   -> grants alternate 0,1,0,1.
//   -> responses are routed to masters 0,1,0,1 in order.
// - m1 read with s_greqready=0 for 3 cycles, m0 asserted at cycle 2:
//   -> grant stays 1 with fields stable.
//   -> m1 accepted on cycle 4; m0 is granted on the next cycle.
// - 4 reads accepted, s_grspvalid held 0:
//   -> count=4, all mN_greqready=0.
//   -> first response pops; the next request is accepted one cycle later.
// - m0 write addr 0x10 data 0xDEADBEEF, then m1 read addr 0x10:
//   -> FIFO holds only tag 1.
//   -> m1 gets rsp 0xDEADBEEF; m0_grspvalid never asserts.
// - s_grspvalid=1 with FIFO empty:
//   -> s_grspready=1, err_orphan=1 next cycle, stays 1.
//   -> reset clears it to 0.
// - Reset asserted with 2 reads outstanding:
//   -> FIFO empty and rr_ptr=0 the cycle after.
//   -> a later response sets err_orphan.

Source files
------------

// File: rtl/gbx_arbiter2.sv
// gbx_arbiter2: two-master round-robin GBX arbiter with in-order read response routing
module gbx_arbiter2 #(
  parameter int OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_greqvalid,
  input  logic        m0_greqwrite,
  input  logic [31:0] m0_greqaddr,
  input  logic [3:0]  m0_greqlen,
  input  logic [15:0] m0_greqid,
  input  logic [1:0]  m0_greqsize,
  input  logic        m0_greqdvalid,
  input  logic [31:0] m0_greqdata,
  input  logic        m0_greqdlast,
  input  logic [15:0] m0_grequser,
  output logic        m0_greqready,
  output logic        m0_grspvalid,
  output logic [31:0] m0_grspdata,
  output logic        m0_grspwerr,
  output logic        m0_grsprerr,
  output logic [15:0] m0_grspid,
  output logic        m0_grsplast,
  output logic [15:0] m0_grspuser,
  input  logic        m0_grspready,
  input  logic        m1_greqvalid,
  input  logic        m1_greqwrite,
  input  logic [31:0] m1_greqaddr,
  input  logic [3:0]  m1_greqlen,
  input  logic [15:0] m1_greqid,
  input  logic [1:0]  m1_greqsize,
  input  logic        m1_greqdvalid,
  input  logic [31:0] m1_greqdata,
  input  logic        m1_greqdlast,
  input  logic [15:0] m1_grequser,
  output logic        m1_greqready,
  output logic        m1_grspvalid,
  output logic [31:0] m1_grspdata,
  output logic        m1_grspwerr,
  output logic        m1_grsprerr,
  output logic [15:0] m1_grspid,
  output logic        m1_grsplast,
  output logic [15:0] m1_grspuser,
  input  logic        m1_grspready,
  output logic        s_greqvalid,
  output logic        s_greqwrite,
  output logic [31:0] s_greqaddr,
  output logic [3:0]  s_greqlen,
  output logic [15:0] s_greqid,
  output logic [1:0]  s_greqsize,
  output logic        s_greqdvalid,
  output logic [31:0] s_greqdata,
  output logic        s_greqdlast,
  output logic [15:0] s_grequser,
  input  logic        s_greqready,
  input  logic        s_grspvalid,
  input  logic [31:0] s_grspdata,
  input  logic        s_grspwerr,
  input  logic        s_grsprerr,
  input  logic [15:0] s_grspid,
  input  logic        s_grsplast,
  input  logic [15:0] s_grspuser,
  output logic        s_grspready,
  output logic        err_orphan
);
  localparam int AW = $clog2(OUTSTANDING);
  localparam int CW = AW + 1;
  logic                   r_rr;
  logic                   r_lock;
  logic                   r_lidx;
  logic [OUTSTANDING-1:0] r_tag;
  logic [AW-1:0]          r_wp;
  logic [AW-1:0]          r_rp;
  logic [CW-1:0]          r_cnt;
  logic                   r_err;
  logic                   w_grant;
  logic                   w_gvalid;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_acc;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_head;
  // grant selection, request mux and response routing
  always_comb begin
    w_grant      = r_lock ? r_lidx : (m0_greqvalid & m1_greqvalid) ? r_rr : m1_greqvalid;
    w_gvalid     = w_grant ? m1_greqvalid : m0_greqvalid;
    w_full       = r_cnt == CW'(OUTSTANDING);
    w_empty      = r_cnt == '0;
    w_head       = r_tag[r_rp];
    s_greqvalid  = w_gvalid & ~w_full;
    s_greqwrite  = w_grant ? m1_greqwrite  : m0_greqwrite;
    s_greqaddr   = w_grant ? m1_greqaddr   : m0_greqaddr;
    s_greqlen    = w_grant ? m1_greqlen    : m0_greqlen;
    s_greqid     = w_grant ? m1_greqid     : m0_greqid;
    s_greqsize   = w_grant ? m1_greqsize   : m0_greqsize;
    s_greqdvalid = w_grant ? m1_greqdvalid : m0_greqdvalid;
    s_greqdata   = w_grant ? m1_greqdata   : m0_greqdata;
    s_greqdlast  = w_grant ? m1_greqdlast  : m0_greqdlast;
    s_grequser   = w_grant ? m1_grequser   : m0_grequser;
    m0_greqready = ~w_grant & m0_greqvalid & s_greqready & ~w_full;
    m1_greqready = w_grant & m1_greqvalid & s_greqready & ~w_full;
    w_acc        = s_greqvalid & s_greqready;
    w_push       = w_acc & ~s_greqwrite;
    m0_grspvalid = s_grspvalid & ~w_empty & ~w_head;
    m1_grspvalid = s_grspvalid & ~w_empty & w_head;
    s_grspready  = w_empty ? 1'b1 : w_head ? m1_grspready : m0_grspready;
    w_pop        = s_grspvalid & s_grspready & s_grsplast & ~w_empty;
    m0_grspdata  = s_grspdata;
    m0_grspwerr  = s_grspwerr;
    m0_grsprerr  = s_grsprerr;
    m0_grspid    = s_grspid;
    m0_grsplast  = s_grsplast;
    m0_grspuser  = s_grspuser;
    m1_grspdata  = s_grspdata;
    m1_grspwerr  = s_grspwerr;
    m1_grsprerr  = s_grsprerr;
    m1_grspid    = s_grspid;
    m1_grsplast  = s_grsplast;
    m1_grspuser  = s_grspuser;
    err_orphan   = r_err;
  end
  // round-robin pointer, stall lock, read-tag fifo and sticky orphan flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr   <= 1'b0;
      r_lock <= 1'b0;
      r_lidx <= 1'b0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_acc) begin
        r_rr   <= ~w_grant;
        r_lock <= 1'b0;
      end else if (s_greqvalid) begin
        r_lock <= 1'b1;
        r_lidx <= w_grant;
      end
      if (w_push) begin
        r_tag[r_wp] <= w_grant;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      if (s_grspvalid & w_empty) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_gbx_arbiter2.sv
// tb_gbx_arbiter2: vectors, corner sequences and randomized model check for gbx_arbiter2
module tb_gbx_arbiter2;
  logic        clk = 0, reset;
  logic        m0_greqvalid, m0_greqwrite, m0_greqdvalid, m0_greqdlast, m0_greqready;
  logic [31:0] m0_greqaddr, m0_greqdata;
  logic [3:0]  m0_greqlen;
  logic [15:0] m0_greqid, m0_grequser;
  logic [1:0]  m0_greqsize;
  logic        m0_grspvalid, m0_grspwerr, m0_grsprerr, m0_grsplast, m0_grspready;
  logic [31:0] m0_grspdata;
  logic [15:0] m0_grspid, m0_grspuser;
  logic        m1_greqvalid, m1_greqwrite, m1_greqdvalid, m1_greqdlast, m1_greqready;
  logic [31:0] m1_greqaddr, m1_greqdata;
  logic [3:0]  m1_greqlen;
  logic [15:0] m1_greqid, m1_grequser;
  logic [1:0]  m1_greqsize;
  logic        m1_grspvalid, m1_grspwerr, m1_grsprerr, m1_grsplast, m1_grspready;
  logic [31:0] m1_grspdata;
  logic [15:0] m1_grspid, m1_grspuser;
  logic        s_greqvalid, s_greqwrite, s_greqdvalid, s_greqdlast, s_greqready;
  logic [31:0] s_greqaddr, s_greqdata;
  logic [3:0]  s_greqlen;
  logic [15:0] s_greqid, s_grequser;
  logic [1:0]  s_greqsize;
  logic        s_grspvalid, s_grspwerr, s_grsprerr, s_grsplast, s_grspready;
  logic [31:0] s_grspdata;
  logic [15:0] s_grspid, s_grspuser;
  logic        err_orphan;
  int checks = 0, errors = 0;

  gbx_arbiter2 #(.OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset),
    .m0_greqvalid(m0_greqvalid), .m0_greqwrite(m0_greqwrite), .m0_greqaddr(m0_greqaddr),
    .m0_greqlen(m0_greqlen), .m0_greqid(m0_greqid), .m0_greqsize(m0_greqsize),
    .m0_greqdvalid(m0_greqdvalid), .m0_greqdata(m0_greqdata), .m0_greqdlast(m0_greqdlast),
    .m0_grequser(m0_grequser), .m0_greqready(m0_greqready), .m0_grspvalid(m0_grspvalid),
    .m0_grspdata(m0_grspdata), .m0_grspwerr(m0_grspwerr), .m0_grsprerr(m0_grsprerr),
    .m0_grspid(m0_grspid), .m0_grsplast(m0_grsplast), .m0_grspuser(m0_grspuser),
    .m0_grspready(m0_grspready),
    .m1_greqvalid(m1_greqvalid), .m1_greqwrite(m1_greqwrite), .m1_greqaddr(m1_greqaddr),
    .m1_greqlen(m1_greqlen), .m1_greqid(m1_greqid), .m1_greqsize(m1_greqsize),
    .m1_greqdvalid(m1_greqdvalid), .m1_greqdata(m1_greqdata), .m1_greqdlast(m1_greqdlast),
    .m1_grequser(m1_grequser), .m1_greqready(m1_greqready), .m1_grspvalid(m1_grspvalid),
    .m1_grspdata(m1_grspdata), .m1_grspwerr(m1_grspwerr), .m1_grsprerr(m1_grsprerr),
    .m1_grspid(m1_grspid), .m1_grsplast(m1_grsplast), .m1_grspuser(m1_grspuser),
    .m1_grspready(m1_grspready),
    .s_greqvalid(s_greqvalid), .s_greqwrite(s_greqwrite), .s_greqaddr(s_greqaddr),
    .s_greqlen(s_greqlen), .s_greqid(s_greqid), .s_greqsize(s_greqsize),
    .s_greqdvalid(s_greqdvalid), .s_greqdata(s_greqdata), .s_greqdlast(s_greqdlast),
    .s_grequser(s_grequser), .s_greqready(s_greqready),
    .s_grspvalid(s_grspvalid), .s_grspdata(s_grspdata), .s_grspwerr(s_grspwerr),
    .s_grsprerr(s_grsprerr), .s_grspid(s_grspid), .s_grsplast(s_grsplast),
    .s_grspuser(s_grspuser), .s_grspready(s_grspready), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v0, w0, v1, w1, sr;
    logic ev, er0, er1, eg;
  } vec_t;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic idle();
    m0_greqvalid = 0; m0_greqwrite = 0; m0_greqaddr = 32'hA0; m0_greqlen = 0; m0_greqid = 16'h0A;
    m0_greqsize = 2; m0_greqdvalid = 0; m0_greqdata = 32'h1111_0000; m0_greqdlast = 1; m0_grequser = 16'h00A0;
    m1_greqvalid = 0; m1_greqwrite = 0; m1_greqaddr = 32'hB1; m1_greqlen = 0; m1_greqid = 16'h0B;
    m1_greqsize = 2; m1_greqdvalid = 0; m1_greqdata = 32'h2222_0000; m1_greqdlast = 1; m1_grequser = 16'h00B1;
    m0_grspready = 1; m1_grspready = 1; s_greqready = 1;
    s_grspvalid = 0; s_grspdata = 0; s_grspwerr = 0; s_grsprerr = 0; s_grspid = 0; s_grsplast = 1; s_grspuser = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic req(input logic v0, w0, v1, w1, sr);
    m0_greqvalid = v0; m0_greqwrite = w0; m1_greqvalid = v1; m1_greqwrite = w1; s_greqready = sr;
  endtask

  vec_t tbl[10];
  int q[$];
  int last_served, stall_m, g;
  bit gv, full, acc, mdl_err, rsp_rdy, pop;

  initial begin
    tbl[0] = '{0,0,0,0,1, 0,0,0,0};
    tbl[1] = '{1,1,1,1,1, 1,1,0,0};
    tbl[2] = '{1,1,1,1,1, 1,0,1,1};
    tbl[3] = '{1,1,1,1,0, 1,0,0,0};
    tbl[4] = '{1,1,1,1,1, 1,1,0,0};
    tbl[5] = '{1,1,0,0,1, 1,1,0,0};
    tbl[6] = '{0,0,1,1,1, 1,0,1,1};
    tbl[7] = '{1,1,1,1,1, 1,1,0,0};
    tbl[8] = '{1,1,1,1,0, 1,0,0,1};
    tbl[9] = '{1,1,1,1,1, 1,0,1,1};
    do_reset();
    #1;
    chk("rst_sreqvalid", s_greqvalid, 0);
    chk("rst_ready", {m0_greqready, m1_greqready}, 0);
    chk("rst_rspvalid", {m0_grspvalid, m1_grspvalid}, 0);
    chk("rst_err", err_orphan, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req(tbl[i].v0, tbl[i].w0, tbl[i].v1, tbl[i].w1, tbl[i].sr);
      #1;
      chk($sformatf("tbl%0d_sv", i), s_greqvalid, tbl[i].ev);
      chk($sformatf("tbl%0d_r0", i), m0_greqready, tbl[i].er0);
      chk($sformatf("tbl%0d_r1", i), m1_greqready, tbl[i].er1);
      if (tbl[i].ev) chk($sformatf("tbl%0d_addr", i), s_greqaddr, tbl[i].eg ? 32'hB1 : 32'hA0);
    end

    do_reset();
    for (int i = 0; i < 4; i++) begin
      req(1, 0, 1, 0, 1);
      #1;
      chk($sformatf("alt%0d_addr", i), s_greqaddr, (i % 2) ? 32'hB1 : 32'hA0);
      chk($sformatf("alt%0d_ready", i), {m1_greqready, m0_greqready}, (i % 2) ? 2'b10 : 2'b01);
      @(negedge clk);
    end
    #1;
    chk("full_sv", s_greqvalid, 0);
    chk("full_ready", {m1_greqready, m0_greqready}, 0);
    @(negedge clk);
    s_grspvalid = 1; s_grspdata = 32'h100;
    #1;
    chk("full_pop_rv", {m1_grspvalid, m0_grspvalid}, 2'b01);
    chk("full_pop_data", m0_grspdata, 32'h100);
    chk("full_pop_still_blocked", {m1_greqready, m0_greqready}, 0);
    @(negedge clk);
    s_grspvalid = 0;
    #1;
    chk("after_pop_ready", {m1_greqready, m0_greqready}, 2'b01);
    @(negedge clk);
    req(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      s_grspvalid = 1; s_grspdata = 32'h200 + i;
      #1;
      chk($sformatf("route%0d", i), {m1_grspvalid, m0_grspvalid}, (i % 2) ? 2'b01 : 2'b10);
      @(negedge clk);
    end
    s_grspvalid = 0;
    #1;
    chk("route_no_orphan", err_orphan, 0);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      req(i >= 2 && i < 4 || i == 4, 0, i < 4, 0, i >= 3);
      #1;
      chk($sformatf("lock%0d_addr", i), s_greqaddr, i < 4 ? 32'hB1 : 32'hA0);
      chk($sformatf("lock%0d_ready", i), {m1_greqready, m0_greqready}, i == 3 ? 2'b10 : i == 4 ? 2'b01 : 2'b00);
      @(negedge clk);
    end
    do_reset();
    req(1, 0, 1, 0, 0);
    s_grspvalid = 1;
    #1;
    chk("rst_mid_grant0", s_greqaddr, 32'hA0);
    chk("rst_mid_orphan_rv", {m1_grspvalid, m0_grspvalid}, 0);
    chk("rst_mid_orphan_rdy", s_grspready, 1);
    @(negedge clk);
    s_grspvalid = 0; req(0, 0, 0, 0, 1);
    #1;
    chk("rst_mid_err", err_orphan, 1);

    do_reset();
    #1;
    chk("err_cleared", err_orphan, 0);
    req(1, 1, 0, 0, 1);
    m0_greqaddr = 32'h10; m0_greqdata = 32'hDEADBEEF; m0_greqdvalid = 1;
    #1;
    chk("wr_sv", s_greqvalid, 1);
    chk("wr_write", s_greqwrite, 1);
    chk("wr_addr", s_greqaddr, 32'h10);
    chk("wr_data", s_greqdata, 32'hDEADBEEF);
    @(negedge clk);
    req(0, 0, 1, 0, 1);
    m1_greqaddr = 32'h10;
    #1;
    chk("rd_ready", {m1_greqready, m0_greqready}, 2'b10);
    chk("rd_write", s_greqwrite, 0);
    @(negedge clk);
    req(0, 0, 0, 0, 1);
    m0_grspready = 0; s_grspvalid = 1; s_grspdata = 32'hDEADBEEF;
    #1;
    chk("rd_rsp_rv", {m1_grspvalid, m0_grspvalid}, 2'b10);
    chk("rd_rsp_data", m1_grspdata, 32'hDEADBEEF);
    chk("rd_rsp_rdy", s_grspready, 1);
    @(negedge clk);
    m0_grspready = 1;
    #1;
    chk("orph_rv", {m1_grspvalid, m0_grspvalid}, 0);
    chk("orph_rdy", s_grspready, 1);
    chk("orph_err_pre", err_orphan, 0);
    @(negedge clk);
    s_grspvalid = 0;
    #1;
    chk("orph_err", err_orphan, 1);
    @(negedge clk);
    #1;
    chk("orph_sticky", err_orphan, 1);
    do_reset();
    #1;
    chk("orph_reset", err_orphan, 0);

    do_reset();
    q.delete(); last_served = 1; stall_m = -1; mdl_err = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      m0_greqvalid = $urandom_range(0, 9) < 6; m0_greqwrite = $urandom_range(0, 9) < 3; m0_greqaddr = $urandom;
      m1_greqvalid = $urandom_range(0, 9) < 6; m1_greqwrite = $urandom_range(0, 9) < 3; m1_greqaddr = $urandom;
      s_greqready = $urandom_range(0, 9) < 7;
      s_grspvalid = $urandom_range(0, 9) < 4; s_grsplast = $urandom_range(0, 9) < 9;
      m0_grspready = $urandom_range(0, 9) < 7; m1_grspready = $urandom_range(0, 9) < 7;
      #1;
      full = q.size() == 4;
      g = stall_m >= 0 ? stall_m : (m0_greqvalid && m1_greqvalid) ? 1 - last_served : int'(m1_greqvalid);
      gv = g ? m1_greqvalid : m0_greqvalid;
      acc = gv && !full && s_greqready;
      rsp_rdy = q.size() == 0 ? 1'b1 : (q[0] ? m1_grspready : m0_grspready);
      pop = s_grspvalid && rsp_rdy && s_grsplast && q.size() != 0;
      chk("rnd_sv", s_greqvalid, gv && !full);
      chk("rnd_r0", m0_greqready, acc && g == 0);
      chk("rnd_r1", m1_greqready, acc && g == 1);
      if (gv && !full) chk("rnd_addr", s_greqaddr, g ? m1_greqaddr : m0_greqaddr);
      chk("rnd_rv0", m0_grspvalid, s_grspvalid && q.size() != 0 && q[0] == 0);
      chk("rnd_rv1", m1_grspvalid, s_grspvalid && q.size() != 0 && q[0] == 1);
      chk("rnd_srdy", s_grspready, rsp_rdy);
      chk("rnd_err", err_orphan, mdl_err);
      if (s_grspvalid && q.size() == 0) mdl_err = 1;
      if (pop) void'(q.pop_front());
      if (acc) begin
        last_served = g;
        stall_m = -1;
        if (!(g ? m1_greqwrite : m0_greqwrite)) q.push_back(g);
      end else if (gv && !full) stall_m = g;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
